uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//  Serial 8N1 UART receiver; receive-side companion to uart_tx, same BAUD_MULT timing.
//  - Synchronises the asynchronous RX pin and finds the start bit.
//  - Samples each bit at mid-bit, LSB first, and checks the stop bit.
//  - Presents each byte through a valid/ready holding register.
//  - Sits between a board input pin and the top-level FSM (e.g. an echo loopback to uart_tx).
//
// PARAMETERS
//  BAUD_MULT   139   clocks per bit (16 MHz/139 ~= 115200 baud; 3 in SIMULATION); minimum 3
//  HALF_MULT   (BAUD_MULT-1)/2   derived localparam: clocks from start detect to start-bit sample
//
// PORTS
//  i_uart_clk     in   1  system clock, all logic on rising edge
//  i_uart_rst_n   in   1  asynchronous, active-low reset
//  i_rx_data      in   1  serial line, asynchronous to i_uart_clk, idles high
//  i_data_ready   in   1  consumer accepts o_byte_out when high with o_data_valid
//  o_byte_out     out  8  last received byte, stable while o_data_valid=1
//  o_data_valid   out  1  holding register full; level until consumed
//  o_rx_active    out  1  high in START/DATA/STOP states (frame in progress)
//  o_frame_err    out  1  one-cycle pulse: stop bit sampled low
//  o_overrun      out  1  one-cycle pulse: byte completed while holding register full
//
// BEHAVIOUR
//  Reset
//   - Sync flops reset to 1; state IDLE; bit/tick counters reset to 0.
//   - All outputs reset to 0, including o_byte_out=8'h00.
//   - Reset mid-frame aborts the frame with no valid and no error.
//  Synchroniser
//   - Two flops; rx_s is the second flop.
//   - All decisions use rx_s, so pin-to-rx_s latency is 2 clocks.
//  FSM: IDLE, START, DATA, STOP, BREAK
//   - IDLE:  rx_s==0 -> START, tick=0 (this is cycle t0).
//   - START: at tick==HALF_MULT (t0+HALF_MULT), sample rx_s.
//       - rx_s==0 -> DATA, tick=0, bit=0.
//       - rx_s==1 -> IDLE (glitch rejected, no flags).
//   - DATA:  sample at every tick==BAUD_MULT-1, i.e. t0+HALF_MULT+k*BAUD_MULT for k=1..8.
//       - shift <= {rx_s, shift[7:1]} (LSB first).
//       - After bit 7 -> STOP, tick=0.
//   - STOP:  sample at tick==BAUD_MULT-1 (k=9).
//       - rx_s==1 -> deliver byte (see handshake) and go to IDLE.
//       - rx_s==0 -> o_frame_err pulse, byte discarded, go to BREAK.
//   - BREAK: wait for rx_s==1, then IDLE. A held-low line never retriggers START.
//  Tick/bit counters
//   - tick is clog2(BAUD_MULT) bits and clears on every sample.
//   - bit is 3 bits.
//   - No wrap beyond the compare values.
//  Handshake
//   - Consume = o_data_valid && i_data_ready; o_data_valid clears the next cycle.
//   - Delivery: o_byte_out<=shift and o_data_valid<=1 on the cycle after the stop sample (registered).
//   - Delivery while full and not consumed: o_overrun pulse, new byte dropped, old byte/valid kept.
//   - Delivery and consume in the same cycle: new byte loaded, valid stays 1, no overrun.
//   - o_frame_err and o_overrun are never asserted together.
//  Back-to-back frames
//   - Return to IDLE occurs at mid-stop-bit, so a start bit immediately after the stop bit is caught.
//
// STRUCTURE
//  - Shared package uart_pkg:
//      - state encoding constants (IDLE..BREAK);
//      - UART_DATA_BITS=8;
//      - BAUD_MULT defaults (board 139, sim 3), shared with uart_tx and the top.
//  - One natural sub-module: sync_2ff (generic 2-flop bit synchroniser, reset value parameter).
//  - Rest is a single always block FSM plus the holding register.
//
// TESTING  (BAUD_MULT=3, ideal-timed serial driver)
//  1 Send 0xA5, ready=1:
//      - o_data_valid rises once, o_byte_out=8'hA5, o_rx_active low afterwards;
//      - valid rises exactly 2+HALF_MULT+9*BAUD_MULT+1 clocks after the falling pin edge.
//  2 Glitch: pin low for 1 clock, then high:
//      - no START->DATA transition, no valid, no flags, FSM back in IDLE.
//  3 Framing: send 0x3C with stop bit low, then hold low 30 clocks, then high:
//      - o_frame_err one pulse;
//      - no valid, no new frame while held low;
//      - next frame 0x55 received correctly.
//  4 Overrun: ready=0, send 0x11 then 0x22:
//      - valid holds 0x11, o_overrun pulses once at 0x22 completion;
//      - ready=1 consumes 0x11, valid drops.
//  5 Simultaneous: ready pulsed on exactly the delivery cycle of 0x22 with 0x11 held:
//      - o_byte_out becomes 0x22, valid stays 1, no overrun.
//  6 Reset: assert i_uart_rst_n=0 mid DATA of 0xFF:
//      - all outputs 0, FSM IDLE;
//      - after release, 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
//   UART_DATA_BITS   data bits per frame (8N1)
//   BAUD_MULT_BOARD  clocks per bit on the 16 MHz board (~115200 baud)
//   BAUD_MULT_SIM    clocks per bit for fast simulation
//   rx_state_t       receiver FSM states
package uart_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int BAUD_MULT_BOARD = 139;
  localparam int BAUD_MULT_SIM   = 3;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side bundle between the UART receiver and its consumer
//   byte_out    last received byte, stable while data_valid=1
//   data_valid  holding register full
//   data_ready  consumer accepts byte_out when high with data_valid
//   rx_active   frame in progress
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte dropped because the holding register was full
interface uart_rx_if;
  logic [uart_pkg::UART_DATA_BITS-1:0] byte_out;
  logic data_valid;
  logic data_ready;
  logic rx_active;
  logic frame_err;
  logic overrun;
  modport master (output byte_out, data_valid, rx_active, frame_err, overrun, input data_ready);
  modport slave  (input byte_out, data_valid, rx_active, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, both flops load RESET_VAL
//   i_d      asynchronous input
//   o_q      synchronised output, two clocks behind i_d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {r_q, r_meta} <= {RESET_VAL, RESET_VAL};
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ready holding register
//   i_uart_clk    system clock, rising edge
//   i_uart_rst_n  asynchronous active-low reset
//   i_rx_data     serial line, asynchronous, idles high
//   rx_bus        byte/handshake/status bundle (uart_rx_if.master)
module uart_rx import uart_pkg::*; #(
  parameter int BAUD_MULT = BAUD_MULT_BOARD
) (
  input  logic      i_uart_clk,
  input  logic      i_uart_rst_n,
  input  logic      i_rx_data,
  uart_rx_if.master rx_bus
);
  localparam int HALF_MULT = (BAUD_MULT - 1) / 2;
  localparam int TW = $clog2(BAUD_MULT);
  localparam logic [TW-1:0] TICK_HALF = TW'(HALF_MULT);
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_MULT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);
  rx_state_t r_state, w_next;
  logic w_rx_s, w_sample, w_deliver, w_ferr, w_active, w_keep_old;
  logic [TW-1:0] r_tick;
  logic [2:0] r_bit;
  logic [UART_DATA_BITS-1:0] r_shift, r_byte;
  logic r_valid, r_ferr, r_ovr;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk  (i_uart_clk),
    .i_rst_n(i_uart_rst_n),
    .i_d    (i_rx_data),
    .o_q    (w_rx_s)
  );

  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_rx_s) w_next = ST_START;
      ST_START: if (w_sample) w_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_sample && r_bit == BIT_LAST) w_next = ST_STOP;
      ST_STOP:  if (w_sample) w_next = w_rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rx_s) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sample  = (r_state == ST_START) ? (r_tick == TICK_HALF)
              : (r_state == ST_DATA || r_state == ST_STOP) && (r_tick == TICK_LAST);
    w_deliver = (r_state == ST_STOP) && w_sample && w_rx_s;
    w_ferr    = (r_state == ST_STOP) && w_sample && !w_rx_s;
    w_active  = r_state inside {ST_START, ST_DATA, ST_STOP};
  end

  // The detect cycle counts as tick 0, so the first START cycle already holds 1 and
  // the start-bit sample lands HALF_MULT clocks after rx_s first reads low.
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_tick <= (w_sample || r_state == ST_BREAK || (r_state == ST_IDLE && w_rx_s)) ? '0 : r_tick + TW'(1);
      r_bit  <= (r_state == ST_START) ? '0 : (r_state == ST_DATA && w_sample) ? r_bit + 3'd1 : r_bit;
      if (r_state == ST_DATA && w_sample) r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
    end

  // A full register that is not being drained this cycle keeps its byte; the new one is dropped.
  assign w_keep_old = r_valid && !rx_bus.data_ready;

  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n)
    if (!i_uart_rst_n) begin
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_deliver && w_keep_old;
      if (w_deliver && !w_keep_old) begin
        r_byte  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_bus.data_ready) r_valid <= 1'b0;
    end

  assign rx_bus.byte_out   = r_byte;
  assign rx_bus.data_valid = r_valid;
  assign rx_bus.rx_active  = w_active;
  assign rx_bus.frame_err  = r_ferr;
  assign rx_bus.overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a cycle-level model of frame timing and the holding register
module tb_uart_rx;
  import uart_pkg::*;
  localparam int B = BAUD_MULT_SIM;
  localparam int H = (B - 1) / 2;
  localparam int LAT = 2 + H + 9 * B + 1;
  typedef struct {
    int due;
    logic [7:0] b;
    logic ferr;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  uart_rx_if bus ();
  uart_rx #(.BAUD_MULT(B)) dut (
    .i_uart_clk  (clk),
    .i_uart_rst_n(rst_n),
    .i_rx_data   (rx),
    .rx_bus      (bus)
  );
  always #5 clk = ~clk;
  ev_t evq[$];
  ev_t e;
  int win_lo[$], win_hi[$];
  int cyc = 0, total = 0, bad = 0, n_ferr = 0, n_ovr = 0;
  logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, exp_act;
  logic [7:0] m_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // frame whose start bit begins at cycle c: delivery visible at c+LAT, busy from c+3 to mid-stop
  task automatic send(input logic [7:0] b, input logic stop = 1'b1, input int nbits = 10);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    win_lo.push_back(cyc + 3);
    win_hi.push_back(cyc + 2 + H + 9 * B);
    if (nbits == 10) evq.push_back(ev_t'{due: cyc + LAT, b: b, ferr: !stop});
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (B) @(negedge clk);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_byte = 8'h00;
      evq.delete();
      win_lo.delete();
      win_hi.delete();
    end else if (evq.size() > 0 && evq[0].due == cyc) begin
      e = evq.pop_front();
      if (e.ferr) m_ferr = 1'b1;
      else if (m_valid && !bus.data_ready) m_ovr = 1'b1;
      else begin
        m_byte = e.b;
        m_valid = 1'b1;
      end
    end else if (m_valid && bus.data_ready) m_valid = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      exp_act = 1'b0;
      foreach (win_lo[i]) if (cyc >= win_lo[i] && cyc <= win_hi[i]) exp_act = 1'b1;
      chk("valid", 32'(bus.data_valid), 32'(m_valid));
      chk("byte", 32'(bus.byte_out), 32'(m_byte));
      chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      chk("rx_active", 32'(bus.rx_active), 32'(exp_act));
      if (bus.frame_err) n_ferr++;
      if (bus.overrun) n_ovr++;
    end
  end

  initial begin
    bus.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.data_valid), 0);
    chk("rst_byte", 32'(bus.byte_out), 0);
    chk("rst_active", 32'(bus.rx_active), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hA5);
    chk("a5_not_yet", 32'(bus.data_valid), 0);
    @(negedge clk);
    chk("a5_valid", 32'(bus.data_valid), 1);
    chk("a5_byte", 32'(bus.byte_out), 32'hA5);
    repeat (4) @(negedge clk);
    chk("a5_idle", 32'(bus.rx_active), 0);
    win_lo.push_back(cyc + 3);
    win_hi.push_back(cyc + 2 + H);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_active", 32'(bus.rx_active), 0);
    chk("glitch_valid", 32'(bus.data_valid), 0);
    n_ferr = 0;
    send(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    chk("brk_active", 32'(bus.rx_active), 0);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_valid", 32'(bus.data_valid), 0);
    send(8'h55);
    @(negedge clk);
    chk("55_valid", 32'(bus.data_valid), 1);
    chk("55_byte", 32'(bus.byte_out), 32'h55);
    repeat (4) @(negedge clk);
    bus.data_ready = 1'b0;
    n_ovr = 0;
    send(8'h11);
    send(8'h22);
    repeat (3) @(negedge clk);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_byte", 32'(bus.byte_out), 32'h11);
    chk("ovr_valid", 32'(bus.data_valid), 1);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    chk("ovr_drain", 32'(bus.data_valid), 0);
    repeat (4) @(negedge clk);
    n_ovr = 0;
    send(8'h11);
    repeat (3) @(negedge clk);
    send(8'h22);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    chk("sim_byte", 32'(bus.byte_out), 32'h22);
    chk("sim_valid", 32'(bus.data_valid), 1);
    repeat (3) @(negedge clk);
    chk("sim_no_ovr", n_ovr, 0);
    send(8'hFF, 1'b1, 5);
    chk("mid_active", 32'(bus.rx_active), 1);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(bus.data_valid), 0);
    chk("mrst_byte", 32'(bus.byte_out), 0);
    chk("mrst_active", 32'(bus.rx_active), 0);
    chk("mrst_ferr", 32'(bus.frame_err), 0);
    chk("mrst_ovr", 32'(bus.overrun), 0);
    bus.data_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h81);
    @(negedge clk);
    chk("81_valid", 32'(bus.data_valid), 1);
    chk("81_byte", 32'(bus.byte_out), 32'h81);
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
